// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, word functions and round constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_ROUNDS = 64;
    localparam int BLOCK_W    = 512;
    localparam int WIN_DEPTH  = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reverses byte order inside one word (little-endian packed sources).
    function automatic word_t bswap32(input word_t x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Round constants K0..K63, shared with the compression datapath.
    localparam word_t ROUND_K [NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_sched_expand.sv
// sha256_sched_expand: next schedule word from the 16-word sliding window.
// Latency: combinational (0 cycles).
// Backpressure: none; the caller decides when to commit the result.
module sha256_sched_expand
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t w_new
);

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], wrapping mod 2^32.
    assign w_new = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: streams W0..W63 with round index for each accepted 512-bit block.
// Latency: first word valid 1 cycle after block accept; one idle cycle between blocks.
// Backpressure: w_ready low freezes window and outputs; blk_ready low for the whole block.
// Build option: MSG_SCHED_BYTESWAP_EN byte-reverses each 32-bit word at load.
module sha256_msg_schedule #(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [16*WORD_W-1:0]  blk_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WORD_W-1:0]     w_data,
    output logic [5:0]            w_idx,
    output logic                  w_last
);
    import sha256_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    sched_state_t state;
    word_t        window [WIN_DEPTH];
    word_t        next_w;

    // Word i of the block, M0 in the top bits; optionally byte-reversed.
    function automatic word_t load_word(input logic [16*WORD_W-1:0] blk, input int i);
        word_t w;
        w = blk[16*WORD_W-1-WORD_W*i -: WORD_W];
`ifdef MSG_SCHED_BYTESWAP_EN
        w = bswap32(w);
`endif
        return w;
    endfunction

    sha256_sched_expand u_expand (
        .w0    (window[0]),
        .w1    (window[1]),
        .w9    (window[9]),
        .w14   (window[14]),
        .w_new (next_w)
    );

    assign w_data = window[0];

    // Block load, window shift and handshake FSM; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            blk_ready <= 1'b1;
            w_valid   <= 1'b0;
            w_last    <= 1'b0;
            w_idx     <= '0;
            for (int i = 0; i < WIN_DEPTH; i++) window[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < WIN_DEPTH; i++) window[i] <= load_word(blk_data, i);
                        w_idx     <= '0;
                        w_last    <= 1'b0;
                        w_valid   <= 1'b1;
                        blk_ready <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_ready) begin
                        // Expansion runs every beat; words made after j=47 are never emitted.
                        for (int i = 0; i < WIN_DEPTH-1; i++) window[i] <= window[i+1];
                        window[WIN_DEPTH-1] <= next_w;
                        w_idx  <= w_idx + 6'd1;
                        w_last <= (w_idx == LAST_IDX - 6'd1);
                        if (w_idx == LAST_IDX) begin
                            state     <= S_IDLE;
                            w_valid   <= 1'b0;
                            w_last    <= 1'b0;
                            blk_ready <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    logic [5:0]  got_idx [64];
    logic        got_last [64];
    int          n_beats;
    int          n_unstable;
    int          n_blk_ready_hi;

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};

    always #5 clk = ~clk;

    sha256_msg_schedule #(.WORD_W(32), .NUM_ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    // Reference schedule in the textbook W[t-k] form.
    task automatic build_ref(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    // Presents a canonical block in the byte order the DUT build expects.
    function automatic logic [511:0] to_dut(input logic [511:0] b);
        logic [511:0] r;
        r = b;
`ifdef MSG_SCHED_BYTESWAP_EN
        for (int i = 0; i < 16; i++)
            r[32*i +: 32] = {b[32*i +: 8], b[32*i+8 +: 8], b[32*i+16 +: 8], b[32*i+24 +: 8]};
`endif
        return r;
    endfunction

    // Drives blk_valid for one cycle from a negedge; ends on the next negedge.
    task automatic load_block(input logic [511:0] b, input bit hold);
        blk_valid = 1'b1;
        blk_data  = to_dut(b);
        @(negedge clk);
        if (!hold) blk_valid = 1'b0;
    endtask

    // Consumes one block's words, sampling at negedges; records beats and stability.
    task automatic stream(input bit stall);
        logic [31:0] pd;
        logic [5:0]  pi;
        bit          held;
        int          cyc;
        n_beats = 0; n_unstable = 0; n_blk_ready_hi = 0; held = 0; cyc = 0; pd = '0; pi = '0;
        while (n_beats < 64 && cyc < 3000) begin
            if (held && (w_valid !== 1'b1 || w_data !== pd || w_idx !== pi)) n_unstable++;
            if (w_valid === 1'b1 && blk_ready !== 1'b0) n_blk_ready_hi++;
            w_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            held = 0;
            if (w_valid === 1'b1) begin
                if (w_ready) begin
                    got_w[n_beats] = w_data; got_idx[n_beats] = w_idx; got_last[n_beats] = w_last;
                    n_beats++;
                end else begin
                    held = 1; pd = w_data; pi = w_idx;
                end
            end
            cyc++;
            @(negedge clk);
        end
        w_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL reset_blk_ready got=%b want=1", blk_ready); end
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL reset_w_valid got=%b want=0", w_valid); end
        total++; if (w_data !== 32'h0) begin bad++; $display("FAIL reset_w_data got=%h want=0", w_data); end
        total++; if (w_idx !== 6'd0) begin bad++; $display("FAIL reset_w_idx got=%0d want=0", w_idx); end
        total++; if (w_last !== 1'b0) begin bad++; $display("FAIL reset_w_last got=%b want=0", w_last); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle got valid=%b ready=%b want 0/1", w_valid, blk_ready); end
    endtask

    task automatic test_abc(input bit stall);
        build_ref(ABC_BLK);
        load_block(ABC_BLK, 0);
        total++; if (w_valid !== 1'b1 || w_idx !== 6'd0) begin bad++; $display("FAIL abc_latency stall=%0d got valid=%b idx=%0d want 1/0", stall, w_valid, w_idx); end
        total++; if (blk_ready !== 1'b0) begin bad++; $display("FAIL abc_blk_ready_run got=%b want=0", blk_ready); end
        stream(stall);
        total++; if (n_beats != 64) begin bad++; $display("FAIL abc_beats stall=%0d got=%0d want=64", stall, n_beats); end
        total++; if (n_unstable != 0) begin bad++; $display("FAIL abc_stall_stable got=%0d unstable want=0", n_unstable); end
        for (int i = 0; i < n_beats; i++) begin
            total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL abc_w%0d stall=%0d got=%h want=%h", i, stall, got_w[i], exp_w[i]); end
            total++; if (got_idx[i] !== 6'(i)) begin bad++; $display("FAIL abc_idx%0d got=%0d want=%0d", i, got_idx[i], i); end
            total++; if (got_last[i] !== (i == 63)) begin bad++; $display("FAIL abc_last%0d got=%b want=%b", i, got_last[i], (i == 63)); end
        end
        if (n_beats == 64) begin
            total++; if (got_w[0] !== 32'h61626380) begin bad++; $display("FAIL abc_W0 got=%h want=61626380", got_w[0]); end
            total++; if (got_w[15] !== 32'h00000018) begin bad++; $display("FAIL abc_W15 got=%h want=00000018", got_w[15]); end
            total++; if (got_w[16] !== 32'h61626380) begin bad++; $display("FAIL abc_W16 got=%h want=61626380", got_w[16]); end
            total++; if (got_w[17] !== 32'h000F0000) begin bad++; $display("FAIL abc_W17 got=%h want=000f0000", got_w[17]); end
        end
        total++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin bad++; $display("FAIL abc_end_idle got valid=%b ready=%b want 0/1", w_valid, blk_ready); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [511:0] blk_b;
        for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h01234567 * (i + 1) ^ 32'hA5A5_0000;
        build_ref(ABC_BLK);
        load_block(ABC_BLK, 1);
        blk_data = to_dut(blk_b);
        stream(0);
        total++; if (n_beats != 64) begin bad++; $display("FAIL b2b_a_beats got=%0d want=64", n_beats); end
        total++; if (n_blk_ready_hi != 0) begin bad++; $display("FAIL b2b_blk_ready_in_run got=%0d cycles want=0", n_blk_ready_hi); end
        total++; if (got_w[63] !== exp_w[63]) begin bad++; $display("FAIL b2b_a_w63 got=%h want=%h", got_w[63], exp_w[63]); end
        total++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin bad++; $display("FAIL b2b_bubble got valid=%b ready=%b want 0/1", w_valid, blk_ready); end
        @(negedge clk);
        blk_valid = 1'b0;
        build_ref(blk_b);
        total++; if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== exp_w[0]) begin bad++; $display("FAIL b2b_b_first got valid=%b idx=%0d data=%h want 1/0/%h", w_valid, w_idx, w_data, exp_w[0]); end
        stream(0);
        total++; if (n_beats != 64) begin bad++; $display("FAIL b2b_b_beats got=%0d want=64", n_beats); end
        for (int i = 0; i < n_beats; i++) begin
            total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL b2b_b_w%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        build_ref(ABC_BLK);
        load_block(ABC_BLK, 0);
        w_ready = 1'b1;
        cyc = 0;
        while (w_idx !== 6'd20 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (w_idx !== 6'd20 || w_data !== exp_w[20]) begin bad++; $display("FAIL mid_reach20 got idx=%0d data=%h want 20/%h", w_idx, w_data, exp_w[20]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_w_valid got=%b want=0", w_valid); end
        total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_blk_ready got=%b want=1", blk_ready); end
        total++; if (w_idx !== 6'd0 || w_data !== 32'h0 || w_last !== 1'b0) begin bad++; $display("FAIL mid_rst_outputs got idx=%0d data=%h last=%b want 0/0/0", w_idx, w_data, w_last); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (w_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_no_words_after got=%0d valid cycles want=0", seen); end
        w_ready = 1'b0;
        load_block(ABC_BLK, 0);
        total++; if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== exp_w[0]) begin bad++; $display("FAIL mid_restart got valid=%b idx=%0d data=%h want 1/0/%h", w_valid, w_idx, w_data, exp_w[0]); end
        stream(0);
        total++; if (n_beats != 64) begin bad++; $display("FAIL mid_restart_beats got=%0d want=64", n_beats); end
        total++; if (got_w[63] !== exp_w[63] || got_idx[63] !== 6'd63) begin bad++; $display("FAIL mid_restart_w63 got=%h/%0d want=%h/63", got_w[63], got_idx[63], exp_w[63]); end
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        logic [511:0] ones;
        ones = '1;
        build_ref(ones);
        load_block(ones, 0);
        stream(1);
        total++; if (n_beats != 64) begin bad++; $display("FAIL ones_beats got=%0d want=64", n_beats); end
        total++; if (got_w[16] !== 32'h203FFFFC) begin bad++; $display("FAIL ones_W16 got=%h want=203ffffc", got_w[16]); end
        total++; if (got_w[17] !== 32'h203FFFFC) begin bad++; $display("FAIL ones_W17 got=%h want=203ffffc", got_w[17]); end
        for (int i = 0; i < n_beats; i++) begin
            total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL ones_w%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_abc(0);
        test_abc(1);
        test_back_to_back();
        test_reset_mid();
        test_all_ones();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
